// File: rtl/if_id_queue.sv
// IF->ID instruction queue: DEPTH-entry circular FIFO of {PC, Instruction} pairs
// with freeze back-pressure to IF and a one-cycle flush on a taken branch.
module if_id_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         PC_in,
    input  logic [WIDTH-1:0]         Instruction_in,
    input  logic                     in_valid,
    input  logic                     Branch_taken,
    input  logic                     hazard,
    output logic                     freeze,
    output logic [WIDTH-1:0]         PC,
    output logic [WIDTH-1:0]         Instruction,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] pc_mem    [DEPTH];
    logic [WIDTH-1:0] instr_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic empty, full, push, pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    // Full blocks push even when a pop happens, so freeze never depends on hazard.
    assign push  = in_valid && !full && !Branch_taken;
    assign pop   = !empty && !hazard && !Branch_taken;

    assign valid       = !empty;
    assign freeze      = full && !Branch_taken;
    assign count       = count_q;
    assign PC          = empty ? '0 : pc_mem[rd_ptr_q];
    assign Instruction = empty ? '0 : instr_mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (Branch_taken) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is intentionally not reset; empty masks stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= PC_in;
            instr_mem[wr_ptr_q] <= Instruction_in;
        end
    end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Instruction queue between the IF stage and the ID stage.
- Accepts the {PC, Instruction} pairs that IF produces and stores them in a DEPTH-entry circular FIFO.
- Presents the oldest entry to ID, which consumes it when it is not stalled by a hazard.
- Asserts freeze back to IF when the queue is full, and empties itself on Branch_taken to discard wrong-path fetches.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- WIDTH, 32, width of the PC field and of the Instruction field.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- PC_in  input  WIDTH  PC+4 value from IF.
- Instruction_in  input  WIDTH  fetched instruction from IF.
- in_valid  input  1  IF presents a valid fetch this cycle.
- Branch_taken  input  1  branch resolved taken; flush the queue.
- hazard  input  1  ID stalled; head entry must not be popped.
- freeze  output  1  to IF; hold PC this cycle.
- PC  output  WIDTH  head entry PC to ID.
- Instruction  output  WIDTH  head entry instruction to ID.
- valid  output  1  head entry is valid.
- count  output  log2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0. Outputs: valid=0, freeze=0, PC=0, Instruction=0. Storage contents need not be cleared.
- Derived signals:
  - empty = (count==0)
  - full = (count==DEPTH)
  - valid = !empty
  - freeze = full && !Branch_taken (combinational). This lets IF take BranchAddr even when the queue is full.
- Outputs are combinational reads of entry[rd_ptr]. PC=0 and Instruction=0 whenever empty. No read latency: an entry pushed at edge N is visible on the outputs after edge N.
- push = in_valid && !full && !Branch_taken
- pop = valid && !hazard && !Branch_taken
- Normal edge:
  - On push, write {PC_in, Instruction_in} to entry[wr_ptr] and increment wr_ptr modulo DEPTH.
  - On pop, increment rd_ptr modulo DEPTH.
  - count += push - pop. Push and pop in the same cycle leave count unchanged.
- Full: no push, even if a pop happens the same cycle. This avoids a combinational path from hazard to freeze. IF holds its PC under freeze and re-presents the same fetch, so nothing is lost; it is accepted on the first cycle after count drops below DEPTH.
- Empty: pop is suppressed because valid=0. A push into an empty queue appears at the head on the next cycle.
- Branch_taken (synchronous flush): at the next edge wr_ptr=rd_ptr=0 and count=0.
  - Any same-cycle push is discarded; it is wrong-path.
  - Flush takes priority over push, pop and hazard.
  - The head shown during the flush cycle is squashed by ID, which also sees Branch_taken.
- Wrap-around: pointers wrap DEPTH-1 -> 0. Ordering is strictly FIFO across the wrap.
- Reset mid-operation clears all state immediately, regardless of clk. The first push after rst deasserts lands in entry 0.
- Invariant: 0 <= count <= DEPTH at all times. Never overflow, never underflow.

Test Plan:
- Reset then fill: rst=1 for 17ns, then in_valid=1 with PC_in=4,8,12,16,... and hazard=1 -> count goes 1..4, freeze=1 once count=4, fifth fetch (PC 20) not stored, outputs PC=4 throughout.
- Drain with stall release: from the full state set hazard=0, in_valid=0 -> PC sequence 4,8,12,16 on consecutive cycles, then valid=0, PC=0, Instruction=0, count=0.
- Simultaneous push/pop: count=2, in_valid=1, hazard=0 for 6 cycles -> count stays 2, outputs follow push order, pointers wrap past entry 3 with no reordering or loss.
- Full with freeze back-pressure: count=4 and IF holding PC 20 under freeze, drop hazard for one cycle -> pop of PC 4; next cycle PC 20 is pushed, count returns to 4, freeze reasserts.
- Branch flush while full: count=4, Branch_taken=1 for one cycle with in_valid=1 -> freeze=0 in that cycle, count=0 and valid=0 next cycle, no entry from that cycle retained; next push (PC_in=0x100) appears as the head.
- Async reset mid-stream: count=3, pulse rst between clock edges -> count=0, valid=0, freeze=0 immediately without waiting for clk.
